// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  // All-9 pattern for up to 10 digits; callers truncate to their BCD width.
  function automatic logic [39:0] nines(input int digits);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 10; i++)
      if (i < digits) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left by one
// pulling in the next binary bit. The bit leaving the top digit is reported.
module bcd_dabble_step
  import bin2bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                msb,
  output logic [4*DIGITS-1:0] bcd_next,
  output logic                carry
);

  logic [4*DIGITS-1:0] adj;

  // Per-digit add-3 correction (4-bit, no carry between digits), then shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_next = {adj[4*DIGITS-2:0], msb};
    carry    = adj[4*DIGITS-1];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one double-dabble iteration per clock,
// with optional two's-complement input, sign flag and overflow saturation.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_neg,
  output logic                out_ovf
);

  localparam int BW = bcd_width(DIGITS);
  localparam int CW = cnt_width(W);
  localparam logic [BW-1:0] NINES = BW'(nines(DIGITS));

  state_t         state, nxt;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bcd;
  logic [W-1:0]   mag;
  logic           neg, ovf;
  logic [BW-1:0]  step_bcd;
  logic           step_carry;
  logic           ovf_next;
  logic           in_neg;
  logic           last;

  assign in_neg   = (SIGNED != 0) && in_data[W-1];
  assign ovf_next = ovf | step_carry;
  assign last     = (cnt == CW'(1));

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd      (bcd),
    .msb      (mag[W-1]),
    .bcd_next (step_bcd),
    .carry    (step_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = SHIFT;
      end
      SHIFT: if (last) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Scratch register, counter, flags; result registers load on the final iteration
  // and otherwise hold so the display keeps the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bcd     <= '0;
      mag     <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Magnitude is W-bit unsigned, so the most negative value maps exactly.
          mag <= in_neg ? (~in_data + W'(1)) : in_data;
          neg <= in_neg;
          bcd <= '0;
          ovf <= 1'b0;
          cnt <= CW'(W);
        end
        SHIFT: begin
          bcd <= step_bcd;
          mag <= {mag[W-2:0], 1'b0};
          ovf <= ovf_next;
          cnt <= cnt - CW'(1);
          if (last) begin
            out_bcd <= ovf_next ? NINES : step_bcd;
            out_neg <= neg;
            out_ovf <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: four converter configurations driven in lockstep, results
// compared against an arithmetic (divide/modulo) reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [15:0] data;

  logic u_rdy, u_vld, u_neg, u_ovf; logic [11:0] u_bcd;
  logic s_rdy, s_vld, s_neg, s_ovf; logic [11:0] s_bcd;
  logic o_rdy, o_vld, o_neg, o_ovf; logic [7:0]  o_bcd;
  logic w_rdy, w_vld, w_neg, w_ovf; logic [19:0] w_bcd;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_rdy), .in_data(data[7:0]),
    .out_valid(u_vld), .out_ready(out_ready), .out_bcd(u_bcd), .out_neg(u_neg), .out_ovf(u_ovf));
  bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_rdy), .in_data(data[7:0]),
    .out_valid(s_vld), .out_ready(out_ready), .out_bcd(s_bcd), .out_neg(s_neg), .out_ovf(s_ovf));
  bin2bcd_seq #(.W(8), .DIGITS(2), .SIGNED(0)) o_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_rdy), .in_data(data[7:0]),
    .out_valid(o_vld), .out_ready(out_ready), .out_bcd(o_bcd), .out_neg(o_neg), .out_ovf(o_ovf));
  bin2bcd_seq #(.W(16), .DIGITS(5), .SIGNED(0)) w_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_rdy), .in_data(data),
    .out_valid(w_vld), .out_ready(out_ready), .out_bcd(w_bcd), .out_neg(w_neg), .out_ovf(w_ovf));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: {ovf, bcd}; saturates to all 9s when the value needs more digits.
  function automatic logic [40:0] model(input longint mag, input int digits);
    logic [40:0] r;
    longint lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r = '0;
    if (mag >= lim) begin
      r[40] = 1'b1;
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
    return r;
  endfunction

  // One conversion on all four DUTs; optional backpressure hold of `hold` cycles.
  task automatic convert(input logic [15:0] v, input int hold);
    int lat8, lat16;
    logic [40:0] eu, es, eo, ew;
    logic signed [7:0] sb;
    longint sv;
    sb = v[7:0];
    sv = sb;
    eu = model(longint'(v[7:0]), 3);
    es = model(sv < 0 ? -sv : sv, 3);
    eo = model(longint'(v[7:0]), 2);
    ew = model(longint'(v), 5);

    check($sformatf("idle_rdy %0h", v), {u_rdy, s_rdy, o_rdy, w_rdy}, 4'hF);
    in_valid = 1'b1; data = v;
    @(negedge clk);
    in_valid = 1'b0; data = 16'($urandom);
    lat8 = 0; lat16 = 0;
    for (int c = 0; c <= 40; c++) begin
      if (u_vld && lat8 == 0) lat8 = c;
      if (w_vld && lat16 == 0) lat16 = c;
      if (lat8 != 0 && lat16 != 0) break;
      @(negedge clk);
    end
    check($sformatf("lat8 %0h", v), lat8, 8);
    check($sformatf("lat16 %0h", v), lat16, 16);
    check($sformatf("vld8 %0h", v), {s_vld, o_vld}, 2'b11);
    check($sformatf("u_bcd %0h", v), {u_ovf, u_neg, u_bcd}, {eu[40], 1'b0, eu[11:0]});
    check($sformatf("s_bcd %0h", v), {s_ovf, s_neg, s_bcd}, {es[40], sv < 0, es[11:0]});
    check($sformatf("o_bcd %0h", v), {o_ovf, o_neg, o_bcd}, {eo[40], 1'b0, eo[7:0]});
    check($sformatf("w_bcd %0h", v), {w_ovf, w_neg, w_bcd}, {ew[40], 1'b0, ew[19:0]});

    if (hold > 0) begin
      in_valid = 1'b1; data = 16'($urandom);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out", {u_vld, u_rdy, w_rdy, u_bcd}, {1'b1, 1'b0, 1'b0, eu[11:0]});
      end
      in_valid = 1'b0;
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("release %0h", v), {u_rdy, s_rdy, o_rdy, w_rdy, u_vld, s_vld, o_vld, w_vld}, 8'hF0);
    check($sformatf("held %0h", v), {o_ovf, s_bcd, w_bcd}, {eo[40], es[11:0], ew[19:0]});
  endtask

  initial begin
    int a8[$], a16[$];
    int seen;
    in_valid = 1'b0; out_ready = 1'b0; data = '0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("reset_state", {u_rdy, w_rdy, u_vld, w_vld, u_bcd, w_bcd, s_neg, o_ovf},
          {1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 20'h0, 1'b0, 1'b0});

    // Directed corner values, then random ones.
    convert(16'd255, 0);
    convert(16'h0080, 0);
    convert(16'h0000, 0);
    convert(16'd100, 0);
    convert(16'd42, 0);
    convert(16'hFFFF, 0);
    convert(16'h007F, 0);
    convert(16'd99, 0);
    convert(16'd1000, 5);
    for (int i = 0; i < 20; i++) convert(16'($urandom), 0);

    // Reset in the middle of the iterations discards the conversion.
    convert(16'd255, 0);
    in_valid = 1'b1; data = 16'd200;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset", {u_rdy, w_rdy, u_vld, w_vld, u_bcd, w_bcd, o_ovf},
          {1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 20'h0, 1'b0});
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_vld || w_vld) seen = 1;
    end
    check("no_out_after_reset", seen, 0);
    convert(16'd37, 0);

    // Throughput with both handshakes held high: W+2 cycles per result.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      data = 16'($urandom);
      if (u_rdy) a8.push_back(c);
      if (w_rdy) a16.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("thru8", (a8.size() >= 2) ? a8[1] - a8[0] : -1, 10);
    check("thru16", (a16.size() >= 2) ? a16[1] - a16[0] : -1, 18);
    for (int c = 0; c < 20; c++) @(negedge clk);
    out_ready = 1'b0;
    convert(16'd12345, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
